// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, constants and helpers for the sequential
// binary-to-BCD converter (double dabble, one bit per clock).

package bin2bcd_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_W = 4;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count D with 10^D > 2^n - 1, i.e. 10^D >= 2^n.
    // 64-bit arithmetic, so this is meaningful for n up to about 60.
    function automatic int min_digits(input int n);
        longint unsigned limit;
        longint unsigned pow10;
        int              d;
        limit = longint'(1) << n;
        pow10 = 1;
        d     = 0;
        while (pow10 < limit) begin
            pow10 = pow10 * 10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/dabble_digit.sv
// dabble_digit: combinational add-3 correction for one BCD digit.
// Any digit of 5 or more gets 3 added so that the following left shift
// carries correctly into the next decade. The result never exceeds 12, so
// 4-bit arithmetic is enough.

module dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_W'(5)) ? digit_in + BCD_W'(3) : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// One binary bit is consumed per clock, with valid/ready handshakes on the
// input and the output side. A conversion takes N shift cycles.
// Optional feature macro: BIN2BCD_SEQ_OVF_EN adds a sticky 'ovf' output
// flagging results that did not fit in DIGITS digits. Without it, such
// results wrap modulo 10^DIGITS.

module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int N      = 20,
    parameter int DIGITS = 7
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] out_bcd
`ifdef BIN2BCD_SEQ_OVF_EN
    ,
    output logic                    ovf
`endif
);

    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int BCD_TOTAL = BCD_W * DIGITS;

    state_t               state;
    state_t               state_next;
    logic [N-1:0]         bin_q;
    logic [BCD_TOTAL-1:0] acc_q;
    logic [BCD_TOTAL-1:0] acc_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept;
    logic                 shifting;

    assign accept   = in_valid && in_ready;
    assign shifting = (state == SHIFT);

    // One add-3 correction cell per decade of the accumulator.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        dabble_digit u_digit (
            .digit_in  (acc_q[BCD_W*d +: BCD_W]),
            .digit_out (acc_adj[BCD_W*d +: BCD_W])
        );
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs, which depend on state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, then correct-and-shift once per SHIFT
    // cycle. The bit leaving the top digit is dropped by the width cast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            bin_q <= in_bin;
            acc_q <= '0;
            cnt_q <= CNT_W'(N - 1);
        end else if (shifting) begin
            acc_q <= BCD_TOTAL'({acc_adj, bin_q[N-1]});
            bin_q <= bin_q << 1;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign out_bcd = acc_q;

`ifdef BIN2BCD_SEQ_OVF_EN
    // When DIGITS covers the full N-bit range nothing can ever be shifted
    // out, so the flag folds away to a constant zero.
    localparam bit OVF_POSSIBLE = (DIGITS < min_digits(N));

    logic ovf_q;

    // Sticky overflow flag: cleared on acceptance, set by any 1 leaving the top digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (shifting && OVF_POSSIBLE && acc_adj[BCD_TOTAL-1]) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq.
// Two instances share the same stimulus: N=20 with DIGITS=7 (full range)
// and N=20 with DIGITS=6 (wraps modulo 10^6). With BIN2BCD_SEQ_OVF_EN
// defined, the ovf outputs are checked as well.

module tb_bin2bcd_seq;

    localparam int N = 20;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready7;
    logic          in_ready6;
    logic [N-1:0]  in_bin;
    logic          out_valid7;
    logic          out_valid6;
    logic          out_ready;
    logic [27:0]   out_bcd7;
    logic [23:0]   out_bcd6;
`ifdef BIN2BCD_SEQ_OVF_EN
    logic          ovf7;
    logic          ovf6;
`endif

    int tests_run;
    int tests_failed;

    bin2bcd_seq #(.N(N), .DIGITS(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready7),
        .in_bin    (in_bin),
        .out_valid (out_valid7),
        .out_ready (out_ready),
        .out_bcd   (out_bcd7)
`ifdef BIN2BCD_SEQ_OVF_EN
        ,
        .ovf       (ovf7)
`endif
    );

    bin2bcd_seq #(.N(N), .DIGITS(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .in_bin    (in_bin),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .out_bcd   (out_bcd6)
`ifdef BIN2BCD_SEQ_OVF_EN
        ,
        .ovf       (ovf6)
`endif
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer one value at a negedge, hold it for exactly one rising edge,
    // then scramble in_bin so any late sampling would show up.
    task automatic applyStimulus(input logic [N-1:0] value);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready7 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_accept", {31'd0, in_ready7}, 32'd1);
        in_valid = 1'b1;
        in_bin   = value;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = ~value;
    endtask

    // Count rising edges until out_valid, bounded; 100 means it never came.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid7) break;
        end
    endtask

    logic [N-1:0]  vec_in  [5];
    logic [27:0]   vec_e7  [5];
    logic [23:0]   vec_e6  [5];
`ifdef BIN2BCD_SEQ_OVF_EN
    logic          vec_ovf [5];
`endif
    logic [N-1:0]  b2b_in  [3];
    logic [27:0]   b2b_e7  [3];
    logic [23:0]   b2b_e6  [3];

    initial begin
        int   cycles;
        bit   saw_valid;
        int   accepted;
        int   results;
        int   last_acc;

        tests_run    = 0;
        tests_failed = 0;

        vec_in[0] = 20'd0;       vec_e7[0] = 28'h0000000; vec_e6[0] = 24'h000000;
        vec_in[1] = 20'd1048575; vec_e7[1] = 28'h1048575; vec_e6[1] = 24'h048575;
        vec_in[2] = 20'd999999;  vec_e7[2] = 28'h0999999; vec_e6[2] = 24'h999999;
        vec_in[3] = 20'd9;       vec_e7[3] = 28'h0000009; vec_e6[3] = 24'h000009;
        vec_in[4] = 20'd1000000; vec_e7[4] = 28'h1000000; vec_e6[4] = 24'h000000;
`ifdef BIN2BCD_SEQ_OVF_EN
        vec_ovf[0] = 1'b0; vec_ovf[1] = 1'b1; vec_ovf[2] = 1'b0;
        vec_ovf[3] = 1'b0; vec_ovf[4] = 1'b1;
`endif
        b2b_in[0] = 20'd314159; b2b_e7[0] = 28'h0314159; b2b_e6[0] = 24'h314159;
        b2b_in[1] = 20'd271828; b2b_e7[1] = 28'h0271828; b2b_e6[1] = 24'h271828;
        b2b_in[2] = 20'd65535;  b2b_e7[2] = 28'h0065535; b2b_e6[2] = 24'h065535;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b1;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready",  {31'd0, in_ready7},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid7}, 32'd0);
        checkOutput("rst_out_bcd7",  {4'd0, out_bcd7},    32'd0);
        checkOutput("rst_out_bcd6",  {8'd0, out_bcd6},    32'd0);
`ifdef BIN2BCD_SEQ_OVF_EN
        checkOutput("rst_ovf6",      {31'd0, ovf6},       32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed conversions with latency, result and return-to-idle checks.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vec_in[i]);
            waitResult(cycles);
            checkOutput($sformatf("latency_%0d", i), cycles, 32'd20);
            checkOutput($sformatf("bcd7_%0d", i), {4'd0, out_bcd7}, {4'd0, vec_e7[i]});
            checkOutput($sformatf("bcd6_%0d", i), {8'd0, out_bcd6}, {8'd0, vec_e6[i]});
`ifdef BIN2BCD_SEQ_OVF_EN
            checkOutput($sformatf("ovf7_%0d", i), {31'd0, ovf7}, 32'd0);
            checkOutput($sformatf("ovf6_%0d", i), {31'd0, ovf6}, {31'd0, vec_ovf[i]});
`endif
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_valid_%0d", i), {31'd0, out_valid7}, 32'd0);
            checkOutput($sformatf("idle_ready_%0d", i), {31'd0, in_ready7}, 32'd1);
        end

        // Backpressure in DONE and in_valid pulses while busy.
        out_ready = 1'b0;
        applyStimulus(20'd500000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_in_ready", {31'd0, in_ready7}, 32'd0);
        in_valid = 1'b1;
        in_bin   = 20'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(cycles);
        checkOutput("bp_valid_seen", {31'd0, out_valid7}, 32'd1);
        checkOutput("bp_bcd7", {4'd0, out_bcd7}, {4'd0, 28'h0500000});
        in_valid = 1'b1;
        in_bin   = 20'd3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold_valid_%0d", k), {31'd0, out_valid7}, 32'd1);
            checkOutput($sformatf("bp_hold_bcd7_%0d", k), {4'd0, out_bcd7}, {4'd0, 28'h0500000});
            checkOutput($sformatf("bp_hold_ready_%0d", k), {31'd0, in_ready7}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", {31'd0, out_valid7}, 32'd0);
        checkOutput("bp_idle_keeps_bcd", {4'd0, out_bcd7}, {4'd0, 28'h0500000});
        @(posedge clk);
        #1;
        checkOutput("bp_no_spurious_accept", {31'd0, in_ready7}, 32'd1);

        // Asynchronous reset after ten shifts of 123456, then convert 42.
        applyStimulus(20'd123456);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready",  {31'd0, in_ready7},  32'd1);
        checkOutput("abort_out_valid", {31'd0, out_valid7}, 32'd0);
        checkOutput("abort_bcd7",      {4'd0, out_bcd7},    32'd0);
        checkOutput("abort_bcd6",      {8'd0, out_bcd6},    32'd0);
`ifdef BIN2BCD_SEQ_OVF_EN
        checkOutput("abort_ovf6",      {31'd0, ovf6},       32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid7) saw_valid = 1'b1;
        end
        checkOutput("abort_no_result", {31'd0, saw_valid}, 32'd0);
        applyStimulus(20'd42);
        waitResult(cycles);
        checkOutput("after_abort_latency", cycles, 32'd20);
        checkOutput("after_abort_bcd7", {4'd0, out_bcd7}, {4'd0, 28'h0000042});
        checkOutput("after_abort_bcd6", {8'd0, out_bcd6}, {8'd0, 24'h000042});

        // Back-to-back with in_valid held high and changing data.
        @(negedge clk);
        accepted = 0;
        results  = 0;
        last_acc = 0;
        in_valid = 1'b1;
        in_bin   = b2b_in[0];
        for (int c = 0; c < 200 && results < 3; c++) begin
            @(negedge clk);
            if (out_valid7) begin
                checkOutput($sformatf("b2b_bcd7_%0d", results), {4'd0, out_bcd7},
                            {4'd0, b2b_e7[results]});
                checkOutput($sformatf("b2b_bcd6_%0d", results), {8'd0, out_bcd6},
                            {8'd0, b2b_e6[results]});
                results++;
            end
            if (in_ready7 && accepted < 3) begin
                if (accepted > 0) begin
                    checkOutput($sformatf("b2b_spacing_%0d", accepted), c - last_acc, 32'd22);
                end
                last_acc = c;
                accepted++;
                @(posedge clk);
                #1;
                if (accepted < 3) begin
                    in_bin = b2b_in[accepted];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput("b2b_results", results, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock, behind a valid/ready handshake on both sides. It is the clocked, area-lean counterpart of the combinational BCD conversion datapath. It sits between an N-bit binary producer (for example, the output of the N-bit difference unit) and a decimal display or formatting consumer.

## Interface
- N, 20, binary input width in bits (N ≥ 1).
- DIGITS, 7, number of BCD output digits. The default covers 2^20−1 = 1048575.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  `in_bin` holds a value to convert.
- in_ready  out  1  block can accept a value. High only in IDLE.
- in_bin  in  N  unsigned binary operand.
- out_valid  out  1  `out_bcd` holds a completed result.
- out_ready  in  1  consumer takes the result.
- out_bcd  out  4*DIGITS  packed BCD result. Digit i occupies [4i+3:4i]; digit 0 is the least significant.
- ovf  out  1  result did not fit in DIGITS digits. Present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_bin` into the shift register, clear the BCD accumulator, load the bit counter with N−1, go to SHIFT.
- SHIFT, once per cycle:
  - For every digit ≥ 5, add 3.
  - Then shift {accumulator, binary} left by one; the binary MSB enters BCD bit 0.
  - If the counter is 0, go to DONE; otherwise decrement it.
- DONE
  - `out_valid`=1 and `out_bcd` = accumulator.
  - On `out_valid && out_ready`: go to IDLE.
- While not in IDLE, `in_valid` is ignored and `in_bin` is not sampled.
- Add-3 correction uses 4-bit arithmetic per digit. A corrected digit is always ≤ 12, so the following shift never produces an invalid digit.
- Bits shifted out of the top digit are discarded. With DIGITS sufficient for N, this cannot occur.
- DIGITS too small for N is legal; the result is then the value modulo 10^DIGITS.
- Counter width is $clog2(N), minimum 1.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE, `in_ready`=1, `out_valid`=0, `out_bcd`=0, `ovf`=0, counter=0.
- Reset mid-SHIFT or mid-DONE aborts the conversion immediately; no result is emitted.
- Latency:
  - Acceptance edge E0. Shifts occur at E1..EN.
  - `out_valid` rises after EN, i.e. N cycles after acceptance.
- Throughput: one conversion per N+2 cycles minimum (accept, N shifts, one DONE cycle with `out_ready`=1, return to IDLE).
- `out_bcd` and `ovf` are registered and stable for the whole DONE interval under backpressure.
- `out_bcd` keeps its last value in IDLE until the next acceptance.
- `in_ready` is combinational from state only; there is no path from `in_valid` to `in_ready`.

## Configuration
- Macro: BIN2BCD_SEQ_OVF_EN.
- Defined:
  - Port `ovf` exists.
  - `ovf` is a sticky bit, cleared on acceptance and set during SHIFT if any 1 bit is shifted out of the top digit.
  - `ovf` is valid with `out_valid`.
- Undefined:
  - No `ovf` port and no overflow logic.
  - Overflowing results silently wrap modulo 10^DIGITS.

## Structure
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constant function min_digits(N) = smallest D with 10^D > 2^N−1.
  - Localparam for BCD digit width (4).
- Sub-module dabble_digit: combinational 4-bit cell, out = (in ≥ 5) ? in+3 : in. Instantiated DIGITS times via generate.

## Test plan
- N=20, DIGITS=7, in_bin=0 → `out_valid` exactly 20 cycles after acceptance, `out_bcd`=28'h0000000.
- in_bin=1048575 → `out_bcd`=28'h1048575; in_bin=999999 → 28'h0999999; in_bin=9 → 28'h0000009.
- `out_ready` held low 5 cycles in DONE → `out_valid` stays 1, `out_bcd` unchanged; `in_valid` pulses during SHIFT/DONE are ignored (`in_ready`=0), and the next result equals the originally accepted value.
- `rst_n` low at shift 10 of a conversion of 123456 → all outputs 0 asynchronously, state IDLE. A new conversion of 42 after release yields 28'h0000042.
- Back-to-back: `in_valid` held high with changing data, `out_ready`=1 → acceptances spaced N+2 cycles apart, each result correct, none dropped.
- With BIN2BCD_SEQ_OVF_EN, N=20, DIGITS=6:
  - in_bin=1000000 → `ovf`=1, `out_bcd`=24'h000000.
  - in_bin=999999 → `ovf`=0, `out_bcd`=24'h999999.
